// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the N-way registered multiplexer.
//   mode_e : select-mode encoding (explicit select or round-robin).
// ---------------------------------------------------------------------------
package mux_pkg;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

endpackage : mux_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter owning its rotating priority pointer.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req        : per-channel request vector
//   advance    : a grant was consumed this cycle; move pointer past it
//   grant      : index of the granted channel (valid when grant_vld)
//   grant_vld  : at least one request is pending
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N_CH  = 4,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   req,
   input  logic              advance,
   output logic [SEL_W-1:0]  grant,
   output logic              grant_vld
);

   logic [SEL_W-1:0] rr_ptr_r;

   // Scan from rr_ptr upward with wrap; first requester wins.
   always_comb begin
      int   idx_i;
      logic hit_s;
      grant     = {SEL_W{1'b0}};
      grant_vld = 1'b0;
      idx_i     = 0;
      hit_s     = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         idx_i = int'(rr_ptr_r) + k;
         idx_i = (idx_i >= N_CH) ? (idx_i - N_CH) : idx_i;
         // Constant-index compare avoids a variable bit-select on req.
         for (int i = 0; i < N_CH; i++) begin
            hit_s     = (idx_i == i) && req[i] && !grant_vld;
            grant     = hit_s ? SEL_W'(i) : grant;
            grant_vld = grant_vld | hit_s;
         end
      end
   end

   // Pointer moves one past the consumed grant, wrapping N_CH-1 -> 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_r <= {SEL_W{1'b0}};
      end else if (advance) begin
         if (grant == SEL_W'(N_CH - 1)) begin
            rr_ptr_r <= {SEL_W{1'b0}};
         end else begin
            rr_ptr_r <= grant + SEL_W'(1);
         end
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

endmodule : rr_arbiter

// File: rtl/mux_nway.sv
// ---------------------------------------------------------------------------
// mux_nway
// N_CH-channel, WIDTH-bit registered multiplexer with valid/ready handshake.
// Channel is chosen by explicit select (MODE_FIXED) or round-robin (MODE_RR).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready (combinational, one-hot or zero)
//   mode       : 0 = MODE_FIXED, 1 = MODE_RR
//   sel        : channel select used in MODE_FIXED
//   out_data   : registered output word
//   out_valid  : registered output valid
//   out_ch     : registered source channel of out_data
//   out_ready  : consumer ready
// ---------------------------------------------------------------------------
module mux_nway
   import mux_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int WIDTH = 8,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   output logic [SEL_W-1:0]      out_ch,
   input  logic                  out_ready
);

   mode_e             mode_s;
   logic              load_s;
   logic              fix_vld_s;
   logic [SEL_W-1:0]  rr_grant_s;
   logic              rr_vld_s;
   logic [SEL_W-1:0]  grant_s;
   logic              grant_vld_s;
   logic [WIDTH-1:0]  grant_data_s;
   logic              accept_s;
   logic              advance_s;

   logic [WIDTH-1:0]  out_data_r;
   logic              out_valid_r;
   logic [SEL_W-1:0]  out_ch_r;

   assign mode_s = mode_e'(mode);

   // Output register can take a word when empty or draining this cycle.
   assign load_s = !out_valid_r || out_ready;

   // Fixed-select validity; a select beyond N_CH-1 matches no channel.
   always_comb begin
      fix_vld_s = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         fix_vld_s = fix_vld_s | ((sel == SEL_W'(i)) & in_valid[i]);
      end
   end

   rr_arbiter #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_rr_arbiter (
      .clk       (clk),
      .rst       (rst),
      .req       (in_valid),
      .advance   (advance_s),
      .grant     (rr_grant_s),
      .grant_vld (rr_vld_s)
   );

   // Mode mux between fixed select and round-robin grant.
   always_comb begin
      case (mode_s)
         MODE_FIXED: begin
            grant_s     = sel;
            grant_vld_s = fix_vld_s;
         end
         MODE_RR: begin
            grant_s     = rr_grant_s;
            grant_vld_s = rr_vld_s;
         end
         default: begin
            grant_s     = {SEL_W{1'b0}};
            grant_vld_s = 1'b0;
         end
      endcase
   end

   // Ready is one-hot on the granted channel; forced low during reset.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         in_ready[i] = !rst && grant_vld_s && load_s && (grant_s == SEL_W'(i));
      end
   end

   // Data of the granted channel, AND-OR selected.
   always_comb begin
      grant_data_s = {WIDTH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
         grant_data_s = grant_data_s |
                        ({WIDTH{grant_s == SEL_W'(i)}} & in_data[i*WIDTH +: WIDTH]);
      end
   end

   // grant_vld implies in_valid on the granted channel, so this is the input transfer.
   assign accept_s  = |(in_ready & in_valid);
   assign advance_s = accept_s && (mode_s == MODE_RR);

   // Output register: load on accept, clear valid on drain-only, else hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_r  <= {WIDTH{1'b0}};
         out_valid_r <= 1'b0;
         out_ch_r    <= {SEL_W{1'b0}};
      end else if (accept_s) begin
         out_data_r  <= grant_data_s;
         out_valid_r <= 1'b1;
         out_ch_r    <= grant_s;
      end else if (out_valid_r && out_ready) begin
         out_data_r  <= out_data_r;
         out_valid_r <= 1'b0;
         out_ch_r    <= out_ch_r;
      end else begin
         out_data_r  <= out_data_r;
         out_valid_r <= out_valid_r;
         out_ch_r    <= out_ch_r;
      end
   end

   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;
   assign out_ch    = out_ch_r;

endmodule : mux_nway

// File: tb/tb_mux_nway.sv
// ---------------------------------------------------------------------------
// tb_mux_nway
// Self-checking bench for mux_nway (N_CH=4, WIDTH=8, SEL_W=3 so that
// out-of-range selects can be driven).
// ---------------------------------------------------------------------------
module tb_mux_nway;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic            mode;
   logic [SW-1:0]   sel;
   logic [W-1:0]    out_data;
   logic            out_valid;
   logic [SW-1:0]   out_ch;
   logic            out_ready;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic         m_valid;
   logic [W-1:0] m_data;
   int           m_ch;
   int           m_ptr;

   always #5 clk = ~clk;

   mux_nway #(.N_CH(N), .WIDTH(W), .SEL_W(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ch    (out_ch),
      .out_ready (out_ready)
   );

   // Expected ready vector from the handshake rules and current model state.
   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r;
      int  g;
      bit  gv;
      r  = '0;
      g  = 0;
      gv = 1'b0;
      if (rst) return r;
      if (mode == 1'b0) begin
         g  = int'(sel);
         gv = (g < N) ? in_valid[g] : 1'b0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (!gv && in_valid[(m_ptr + k) % N]) begin
               g  = (m_ptr + k) % N;
               gv = 1'b1;
            end
         end
      end
      if (gv && (!m_valid || out_ready)) r[g] = 1'b1;
      return r;
   endfunction

   task automatic model_tick(input logic [N-1:0] r);
      int g;
      g = 0;
      if (rst) begin
         m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
      end else if (r != '0) begin
         for (int i = 0; i < N; i++) if (r[i]) g = i;
         m_data  = in_data[g*W +: W];
         m_ch    = g;
         m_valid = 1'b1;
         if (mode) m_ptr = (g + 1) % N;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
   endtask

   // Advance one clock edge, updating the model with the pre-edge inputs.
   task automatic tick();
      logic [N-1:0] r;
      r = exp_ready();
      @(posedge clk);
      model_tick(r);
      #1;
   endtask

   task automatic set_ch(input int c, input logic [W-1:0] v);
      in_data[c*W +: W] = v;
   endtask

   task automatic test_reset();
      logic [W-1:0] d0;
      @(negedge clk);
      rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1; mode = 1'b1; sel = 3'd0;
      in_data = $urandom;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h ch=%0d expected v=0 d=00 ch=0",
                     out_valid, out_data, out_ch);
         end
         @(negedge clk);
      end
      rst = 1'b0;
      d0  = in_data[7:0];
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         errors++; $display("FAIL reset_release_ready: got %b expected 0001", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_data !== d0) begin
         errors++;
         $display("FAIL reset_first_word: got v=%b d=%h ch=%0d expected v=1 d=%h ch=0",
                  out_valid, out_data, out_ch, d0);
      end
   endtask

   task automatic test_fixed();
      @(negedge clk);
      mode = 1'b0; sel = 3'd2; in_valid = 4'hF; out_ready = 1'b1;
      in_data = $urandom; set_ch(2, 8'hA5);
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin
         errors++; $display("FAIL fixed_ready: got %b expected 0100", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 3'd2) begin
         errors++;
         $display("FAIL fixed_word: got v=%b d=%h ch=%0d expected v=1 d=a5 ch=2",
                  out_valid, out_data, out_ch);
      end
      @(negedge clk);
      sel = 3'd5;
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
         errors++; $display("FAIL fixed_sel_oor_ready: got %b expected 0000", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_ch !== 3'd2) begin
         errors++;
         $display("FAIL fixed_sel_oor_drain: got v=%b d=%h ch=%0d expected v=0 d=a5 ch=2",
                  out_valid, out_data, out_ch);
      end
   endtask

   task automatic test_rr_wrap();
      int seq_all [6] = '{0, 1, 2, 3, 0, 1};
      int seq_sub [3] = '{3, 1, 3};
      @(negedge clk);
      rst = 1'b1; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
      tick();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         in_data = $urandom;
         tick();
         checks++;
         if (out_valid !== 1'b1 || int'(out_ch) != seq_all[k]) begin
            errors++;
            $display("FAIL rr_sequence[%0d]: got v=%b ch=%0d expected v=1 ch=%0d",
                     k, out_valid, out_ch, seq_all[k]);
         end
         @(negedge clk);
      end
      in_valid = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         in_data = $urandom;
         tick();
         checks++;
         if (out_valid !== 1'b1 || int'(out_ch) != seq_sub[k]) begin
            errors++;
            $display("FAIL rr_sparse[%0d]: got v=%b ch=%0d expected v=1 ch=%0d",
                     k, out_valid, out_ch, seq_sub[k]);
         end
         if (k < 2) @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] d2;
      @(negedge clk);
      mode = 1'b0; sel = 3'd1; in_valid = 4'hF; out_ready = 1'b1;
      in_data = $urandom; set_ch(1, 8'h3C);
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
         errors++; $display("FAIL bp_load_ready: got %b expected 0010", in_ready);
      end
      tick();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         out_ready = 1'b0; in_data = $urandom;
         #1;
         checks++;
         if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0000", c, in_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 3'd1) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d expected v=1 d=3c ch=1",
                     c, out_valid, out_data, out_ch);
         end
      end
      @(negedge clk);
      out_ready = 1'b1; sel = 3'd2; in_data = $urandom;
      d2 = in_data[2*W +: W];
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin
         errors++; $display("FAIL bp_release_ready: got %b expected 0100", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== d2 || out_ch !== 3'd2) begin
         errors++;
         $display("FAIL bp_no_bubble: got v=%b d=%h ch=%0d expected v=1 d=%h ch=2",
                  out_valid, out_data, out_ch, d2);
      end
      // Pointer was 0 before the fixed-mode traffic and must still be 0.
      @(negedge clk);
      mode = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         errors++; $display("FAIL bp_ptr_unchanged: got %b expected 0001", in_ready);
      end
      tick();
   endtask

   task automatic test_midstream();
      logic [W-1:0] d1;
      logic [W-1:0] d3;
      @(negedge clk);
      mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1; in_data = $urandom;
      d1 = in_data[1*W +: W];
      tick();
      @(negedge clk);
      out_ready = 1'b0; mode = 1'b0; sel = 3'd3; in_data = $urandom;
      d3 = in_data[3*W +: W];
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== d1 || out_ch !== 3'd1) begin
         errors++;
         $display("FAIL mid_mode_hold: got v=%b d=%h ch=%0d expected v=1 d=%h ch=1",
                  out_valid, out_data, out_ch, d1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b1000) begin
         errors++; $display("FAIL mid_sel_ready: got %b expected 1000", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== d3 || out_ch !== 3'd3) begin
         errors++;
         $display("FAIL mid_sel_word: got v=%b d=%h ch=%0d expected v=1 d=%h ch=3",
                  out_valid, out_data, out_ch, d3);
      end
      @(negedge clk);
      rst = 1'b1; mode = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
         errors++; $display("FAIL mid_rst_ready: got %b expected 0000", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL mid_rst_discard: got v=%b d=%h expected v=0 d=00", out_valid, out_data);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         errors++; $display("FAIL mid_rst_ptr: got %b expected 0001", in_ready);
      end
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0] er;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 49) == 0);
         in_valid  = 4'($urandom);
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         sel       = 3'($urandom_range(0, 7));
         out_ready = ($urandom_range(0, 9) < 7);
         in_data   = $urandom;
         #1;
         er = exp_ready();
         checks++;
         if (in_ready !== er) begin
            errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, in_ready, er);
         end
         tick();
         checks++;
         if (out_valid !== m_valid || out_data !== m_data || int'(out_ch) != m_ch) begin
            errors++;
            $display("FAIL rand_out[%0d]: got v=%b d=%h ch=%0d expected v=%b d=%h ch=%0d",
                     c, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
      m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
      test_reset();
      test_fixed();
      test_rr_wrap();
      test_backpressure();
      test_midstream();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mux_nway
